// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: op codes, PSR layout,
// register select encodings, flag masks and FSM states.
package alu_pkg;

    localparam logic [3:0] ALU_ADC = 4'h0;
    localparam logic [3:0] ALU_SBC = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_OR  = 4'h3;
    localparam logic [3:0] ALU_XOR = 4'h4;
    localparam logic [3:0] ALU_CMP = 4'h5;
    localparam logic [3:0] ALU_INC = 4'h6;
    localparam logic [3:0] ALU_DEC = 4'h7;
    localparam logic [3:0] ALU_ASL = 4'h8;
    localparam logic [3:0] ALU_LSR = 4'h9;
    localparam logic [3:0] ALU_ROR = 4'hA;
    localparam logic [3:0] ALU_ROL = 4'hB;

    localparam int PSR_N = 7;
    localparam int PSR_V = 6;
    localparam int PSR_U = 5;
    localparam int PSR_B = 4;
    localparam int PSR_D = 3;
    localparam int PSR_I = 2;
    localparam int PSR_Z = 1;
    localparam int PSR_C = 0;

    localparam logic [1:0] REG_A   = 2'd0;
    localparam logic [1:0] REG_X   = 2'd1;
    localparam logic [1:0] REG_Y   = 2'd2;
    localparam logic [1:0] REG_MEM = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    function automatic logic op_illegal(input logic [3:0] op);
        return op > ALU_ROL;
    endfunction

    // Flags each op is allowed to change; B and D are never in any mask.
    function automatic logic [7:0] flag_mask(input logic [3:0] op);
        logic [7:0] m;
        m = 8'h00;
        unique case (op)
            ALU_ADC, ALU_SBC: begin
                m[PSR_N] = 1'b1;
                m[PSR_V] = 1'b1;
                m[PSR_Z] = 1'b1;
                m[PSR_C] = 1'b1;
            end
            ALU_CMP, ALU_ASL, ALU_LSR, ALU_ROR, ALU_ROL: begin
                m[PSR_N] = 1'b1;
                m[PSR_Z] = 1'b1;
                m[PSR_C] = 1'b1;
            end
            ALU_AND, ALU_OR, ALU_XOR, ALU_INC, ALU_DEC: begin
                m[PSR_N] = 1'b1;
                m[PSR_Z] = 1'b1;
            end
            default: m = 8'h00;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/alu_flag_merge.sv
// Combinational merge of ALU flags into P under a per-op mask.
// Bit 5 of P always reads as one.
module alu_flag_merge (
    input  logic [7:0] p,
    input  logic [7:0] psr_in,
    input  logic [7:0] mask,
    output logic [7:0] new_p
);

    assign new_p = (p & ~mask) | (psr_in & mask) | 8'h20;

endmodule

// File: rtl/alu_issue_ctrl.sv
// Requester side of the clocked ALU: issues one micro-op at a time,
// writes back the result and merges flags into P.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned ALU_LAT = 1,
    parameter logic [7:0]  P_RESET = 8'h24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_op,
    input  logic [1:0] req_src,
    input  logic [1:0] req_dst,
    input  logic [7:0] req_b,
    input  logic [7:0] req_mem,
    input  logic       p_load_valid,
    input  logic [7:0] p_load_data,
    output logic       p_load_ready,
    output logic [7:0] alu_A,
    output logic [7:0] alu_B,
    output logic       alu_CarryBit,
    output logic [3:0] alu_op,
    output logic       alu_Decimal,
    input  logic [7:0] alu_Result,
    input  logic [7:0] alu_PSRout,
    output logic       rsp_valid,
    output logic [7:0] rsp_result,
    output logic       rsp_err,
    output logic       mem_we,
    output logic [7:0] mem_wdata,
    output logic [7:0] reg_a,
    output logic [7:0] reg_x,
    output logic [7:0] reg_y,
    output logic [7:0] reg_p
);

    localparam logic [1:0] LAT_M1 = 2'(ALU_LAT - 1);

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [7:0] a_q, a_d;
    logic [7:0] x_q, x_d;
    logic [7:0] y_q, y_d;
    logic [7:0] p_q, p_d;
    logic [7:0] alu_a_q, alu_a_d;
    logic [7:0] alu_b_q, alu_b_d;
    logic       alu_c_q, alu_c_d;
    logic [3:0] alu_op_q, alu_op_d;
    logic       alu_dec_q, alu_dec_d;
    logic [3:0] op_q, op_d;
    logic [1:0] dst_q, dst_d;
    logic       ill_q, ill_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_result_q, rsp_result_d;
    logic       rsp_err_q, rsp_err_d;
    logic       mem_we_q, mem_we_d;
    logic [7:0] mem_wdata_q, mem_wdata_d;

    logic [7:0] src_val;
    logic [7:0] merged_p;

    alu_flag_merge u_merge (
        .p      (p_q),
        .psr_in (alu_PSRout),
        .mask   (flag_mask(op_q)),
        .new_p  (merged_p)
    );

    always_comb begin
        unique case (req_src)
            REG_A:   src_val = a_q;
            REG_X:   src_val = x_q;
            REG_Y:   src_val = y_q;
            default: src_val = req_mem;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        a_d          = a_q;
        x_d          = x_q;
        y_d          = y_q;
        p_d          = p_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_c_d      = alu_c_q;
        alu_op_d     = alu_op_q;
        alu_dec_d    = alu_dec_q;
        op_d         = op_q;
        dst_d        = dst_q;
        ill_d        = ill_q;
        rsp_valid_d  = 1'b0;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;
        mem_we_d     = 1'b0;
        mem_wdata_d  = mem_wdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = ST_EXEC;
                    cnt_d   = LAT_M1;
                    op_d    = req_op;
                    dst_d   = req_dst;
                    ill_d   = op_illegal(req_op);
                    // Illegal ops leave the ALU inputs untouched.
                    if (!op_illegal(req_op)) begin
                        alu_a_d   = src_val;
                        alu_b_d   = req_b;
                        alu_op_d  = req_op;
                        alu_c_d   = 1'b0;
                        alu_dec_d = 1'b0;
                        unique case (req_op)
                            ALU_ADC, ALU_SBC: begin
                                alu_c_d   = p_q[PSR_C];
                                alu_dec_d = p_q[PSR_D];
                            end
                            ALU_ROR, ALU_ROL: alu_c_d = p_q[PSR_C];
                            ALU_CMP:          alu_c_d = 1'b1;
                            default:          alu_c_d = 1'b0;
                        endcase
                    end
                end
            end
            ST_EXEC: begin
                if (cnt_q == 2'd0) begin
                    state_d = ST_WB;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            ST_WB: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b1;
                if (ill_q) begin
                    rsp_err_d    = 1'b1;
                    rsp_result_d = 8'h00;
                end else begin
                    rsp_err_d    = 1'b0;
                    rsp_result_d = alu_Result;
                    p_d          = merged_p;
                    if (op_q != ALU_CMP) begin
                        unique case (dst_q)
                            REG_A: a_d = alu_Result;
                            REG_X: x_d = alu_Result;
                            REG_Y: y_d = alu_Result;
                            default: begin
                                mem_we_d    = 1'b1;
                                mem_wdata_d = alu_Result;
                            end
                        endcase
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_q != ST_WB && p_load_valid) begin
            p_d = p_load_data | 8'h20;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 2'd0;
            a_q          <= 8'h00;
            x_q          <= 8'h00;
            y_q          <= 8'h00;
            p_q          <= P_RESET;
            alu_a_q      <= 8'h00;
            alu_b_q      <= 8'h00;
            alu_c_q      <= 1'b0;
            alu_op_q     <= 4'h0;
            alu_dec_q    <= 1'b0;
            op_q         <= 4'h0;
            dst_q        <= 2'd0;
            ill_q        <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= 8'h00;
            rsp_err_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= 8'h00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            a_q          <= a_d;
            x_q          <= x_d;
            y_q          <= y_d;
            p_q          <= p_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_c_q      <= alu_c_d;
            alu_op_q     <= alu_op_d;
            alu_dec_q    <= alu_dec_d;
            op_q         <= op_d;
            dst_q        <= dst_d;
            ill_q        <= ill_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign req_ready    = (state_q == ST_IDLE);
    assign p_load_ready = (state_q != ST_WB);
    assign alu_A        = alu_a_q;
    assign alu_B        = alu_b_q;
    assign alu_CarryBit = alu_c_q;
    assign alu_op       = alu_op_q;
    assign alu_Decimal  = alu_dec_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_err      = rsp_err_q;
    assign mem_we       = mem_we_q;
    assign mem_wdata    = mem_wdata_q;
    assign reg_a        = a_q;
    assign reg_x        = x_q;
    assign reg_y        = y_q;
    assign reg_p        = p_q;

endmodule
